// File: rtl/score_controller_pkg.sv
// Shared defaults, types and BCD helpers for the scoring scheduler and its
// round-robin arbiter.
package score_controller_pkg;

    localparam int DEF_NUM_SOURCES = 4;
    localparam int DEF_NUM_DIGITS  = 4;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } score_ctrl_state_t;

    // One BCD digit add: returns {carry_out, digit}.
    function automatic logic [4:0] bcd_add(input bcd_digit_t a, input bcd_digit_t b,
                                           input logic cin);
        logic [4:0] s;
        logic [4:0] r;
        s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        r = s - 5'd10;
        if (s > 5'd9)
            return {1'b1, r[3:0]};
        return {1'b0, s[3:0]};
    endfunction

    function automatic bcd_digit_t bcd_clamp(input logic [3:0] p);
        return (p > 4'd9) ? 4'd9 : p;
    endfunction

endpackage

// File: rtl/score_controller_rr_arbiter.sv
// Round-robin arbiter: combinational grant starting after the last accepted
// index, pointer advances only when the grant is accepted.
module rr_arbiter
    import score_controller_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_SOURCES,
    parameter int IDXW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic              accept_i,
    output logic [IDXW-1:0]   grant_idx_o,
    output logic              grant_vld_o
);

    logic [IDXW-1:0] ptr_q;

    // Scan from farthest to nearest so the nearest requester after ptr wins.
    always_comb begin
        int idx;
        idx         = 0;
        grant_idx_o = '0;
        grant_vld_o = 1'b0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = (int'(ptr_q) + i) % NUM_REQ;
            if (req_i[idx]) begin
                grant_idx_o = idx[IDXW-1:0];
                grant_vld_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            ptr_q <= IDXW'(NUM_REQ - 1);
        else if (accept_i && grant_vld_o)
            ptr_q <= grant_idx_o;
    end

endmodule

// File: rtl/score_controller.sv
// Scoring scheduler: arbitrates point requests and ripple-adds each granted
// value into a saturating multi-digit BCD score, one digit per cycle.
module score_controller
    import score_controller_pkg::*;
#(
    parameter int NUM_SOURCES = DEF_NUM_SOURCES,
    parameter int NUM_DIGITS  = DEF_NUM_DIGITS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clearScore,
    input  logic [NUM_SOURCES-1:0]  hitReq,
    input  logic [NUM_SOURCES*4-1:0] hitPoints,
    output logic [NUM_SOURCES-1:0]  hitAck,
    output logic [NUM_DIGITS*4-1:0] digits,
    output logic                    scoreChanged,
    output logic                    overflow,
    output logic                    busy
);

    localparam int IDXW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
    localparam int CW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(NUM_DIGITS - 1);
    localparam bcd_digit_t [NUM_DIGITS-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

    score_ctrl_state_t state_q, state_d;
    logic [IDXW-1:0]   grant_q, grant_d;
    bcd_digit_t        points_q, points_d;
    bcd_digit_t [NUM_DIGITS-1:0] work_q, work_d;
    bcd_digit_t [NUM_DIGITS-1:0] digits_q, digits_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              ovf_q, ovf_d;
    logic [NUM_SOURCES-1:0] ack_q, ack_d;
    logic              chg_q, chg_d;
    logic              chg_en_q, chg_en_d;

    logic [NUM_SOURCES-1:0][3:0] pts_w;
    logic [IDXW-1:0]   arb_idx;
    logic              arb_vld;
    logic              accept;
    bcd_digit_t        grant_pts;
    bcd_digit_t        add_sum;
    logic              add_cout;

    assign pts_w = hitPoints;

    rr_arbiter #(
        .NUM_REQ (NUM_SOURCES),
        .IDXW    (IDXW)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req_i       (hitReq),
        .accept_i    (accept),
        .grant_idx_o (arb_idx),
        .grant_vld_o (arb_vld)
    );

    assign grant_pts = bcd_clamp(pts_w[arb_idx]);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        points_d = points_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        digits_d = digits_q;
        ovf_d    = ovf_q;
        chg_en_d = chg_en_q;
        ack_d    = '0;
        chg_d    = 1'b0;
        accept   = 1'b0;
        {add_cout, add_sum} = bcd_add(work_q[cnt_q], (cnt_q == '0) ? points_q : 4'd0, carry_q);

        // Clear aborts any in-flight addition; the pointer is left alone.
        if (clearScore) begin
            state_d  = ST_IDLE;
            digits_d = '0;
            ovf_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_vld) begin
                        accept   = 1'b1;
                        grant_d  = arb_idx;
                        points_d = grant_pts;
                        work_d   = digits_q;
                        carry_d  = 1'b0;
                        cnt_d    = '0;
                        chg_en_d = (grant_pts != 4'd0) && (digits_q != ALL_NINES);
                        state_d  = ST_ADD;
                    end
                end
                ST_ADD: begin
                    work_d[cnt_q] = add_sum;
                    carry_d       = add_cout;
                    cnt_d         = cnt_q + CW'(1);
                    if (cnt_q == LAST_DIGIT) begin
                        digits_d       = add_cout ? ALL_NINES : work_d;
                        ovf_d          = ovf_q | add_cout;
                        ack_d[grant_q] = 1'b1;
                        chg_d          = chg_en_q;
                        state_d        = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            points_q <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            digits_q <= '0;
            ovf_q    <= 1'b0;
            ack_q    <= '0;
            chg_q    <= 1'b0;
            chg_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            points_q <= points_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            digits_q <= digits_d;
            ovf_q    <= ovf_d;
            ack_q    <= ack_d;
            chg_q    <= chg_d;
            chg_en_q <= chg_en_d;
        end
    end

    assign hitAck       = ack_q;
    assign digits       = digits_q;
    assign scoreChanged = chg_q;
    assign overflow     = ovf_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_score_controller.sv
// Directed bench for score_controller: latency, carry ripple, round-robin
// order, clamping, clear abort and saturation.
module tb_score_controller;

    localparam int NS = 4;
    localparam int ND = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            clearScore;
    logic [NS-1:0]   hitReq;
    logic [NS*4-1:0] hitPoints;
    logic [NS-1:0]   hitAck;
    logic [ND*4-1:0] digits;
    logic            scoreChanged;
    logic            overflow;
    logic            busy;

    int n_chk  = 0;
    int n_fail = 0;

    score_controller #(.NUM_SOURCES(NS), .NUM_DIGITS(ND)) dut (
        .clk          (clk),
        .reset        (reset),
        .clearScore   (clearScore),
        .hitReq       (hitReq),
        .hitPoints    (hitPoints),
        .hitAck       (hitAck),
        .digits       (digits),
        .scoreChanged (scoreChanged),
        .overflow     (overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output logic [NS-1:0] a, output int cyc);
        a   = '0;
        cyc = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (hitAck != '0) begin
                a   = hitAck;
                cyc = n;
                break;
            end
        end
        if (cyc == 0) check("ack_timeout", 32'(cyc), 32'd1);
    endtask

    // Raise one request from IDLE, wait for its ack, drop it, return in IDLE.
    task automatic run_hit(input int src, input logic [3:0] pts, output logic [NS-1:0] a,
                           output logic [15:0] d, output logic chg, output int cyc,
                           output logic stable);
        logic [15:0] d0;
        d0     = digits;
        stable = 1'b1;
        a      = '0;
        cyc    = 0;
        hitPoints[src*4 +: 4] = pts;
        hitReq[src] = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (hitAck != '0) begin
                a   = hitAck;
                cyc = n;
                break;
            end
            if (digits != d0) stable = 1'b0;
        end
        if (cyc == 0) check("hit_timeout", 32'(cyc), 32'd1);
        d   = digits;
        chg = scoreChanged;
        hitReq[src] = 1'b0;
        tick();
    endtask

    task automatic pump(input int src, input int n9, input logic [3:0] last);
        logic [NS-1:0] a;
        logic [15:0]   d;
        logic          c;
        logic          s;
        int            cy;
        for (int k = 0; k < n9; k++) run_hit(src, 4'd9, a, d, c, cy, s);
        run_hit(src, last, a, d, c, cy, s);
    endtask

    task automatic do_clear();
        clearScore = 1'b1;
        tick();
        clearScore = 1'b0;
    endtask

    initial begin
        logic [NS-1:0] a;
        logic [15:0]   d;
        logic          c;
        logic          s;
        int            cy;

        reset = 1'b1; clearScore = 1'b0; hitReq = '0; hitPoints = '0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_digits", 32'(digits), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        check("rst_pulses", 32'({hitAck, scoreChanged}), 32'h0);

        // Source 2, points 7: fixed latency to DONE at cycle 5.
        hitPoints[11:8] = 4'd7; hitReq[2] = 1'b1;
        tick();
        check("lat_busy_c1", 32'(busy), 32'h1);
        repeat (3) tick();
        check("lat_c4_no_partial", 32'({hitAck, digits}), 32'h0);
        tick();
        check("lat_ack_c5", 32'(hitAck), 32'h4);
        check("lat_chg_c5", 32'(scoreChanged), 32'h1);
        check("lat_digits_c5", 32'(digits), 32'h0007);
        hitReq[2] = 1'b0;
        tick();
        check("lat_idle_c6", 32'({busy, hitAck, scoreChanged}), 32'h0);

        // 0995 + 5 ripples to 1000.
        do_clear();
        check("clr_digits", 32'(digits), 32'h0);
        pump(0, 110, 4'd5);
        check("pump_0995", 32'(digits), 32'h0995);
        run_hit(0, 4'd5, a, d, c, cy, s);
        check("rip_digits", 32'(d), 32'h1000);
        check("rip_ack", 32'(a), 32'h1);
        check("rip_chg", 32'(c), 32'h1);
        check("rip_stable", 32'(s), 32'h1);
        check("rip_lat", 32'(cy), 32'd5);
        check("rip_chg_single", 32'(scoreChanged), 32'h0);

        // Park the pointer on source 3; zero points leaves scoreChanged low.
        do_clear();
        run_hit(3, 4'd0, a, d, c, cy, s);
        check("zero_ack", 32'(a), 32'h8);
        check("zero_chg", 32'(c), 32'h0);
        check("zero_digits", 32'(d), 32'h0);

        hitPoints = {4'd4, 4'd3, 4'd2, 4'd1};
        hitReq = 4'hF;
        for (int i = 0; i < 4; i++) begin
            wait_ack(a, cy);
            check("rr_order", 32'(a), 32'(1 << i));
            check("rr_spacing", 32'(cy), (i == 0) ? 32'd5 : 32'd6);
            hitReq = hitReq & ~a;
        end
        check("rr_digits", 32'(digits), 32'h0010);
        tick();
        hitReq = 4'b1010;
        wait_ack(a, cy);
        check("rr_wrap_first", 32'(a), 32'h2);
        hitReq = hitReq & ~a;
        wait_ack(a, cy);
        check("rr_wrap_second", 32'(a), 32'h8);
        hitReq = hitReq & ~a;
        check("rr_wrap_digits", 32'(digits), 32'h0016);
        tick();

        // Points 12 clamp to 9; changing points after grant has no effect.
        do_clear();
        hitPoints[11:8] = 4'd12; hitReq[2] = 1'b1;
        tick();
        hitPoints[11:8] = 4'd1;
        wait_ack(a, cy);
        check("clamp_ack", 32'(a), 32'h4);
        check("clamp_lat", 32'(cy), 32'd4);
        check("clamp_digits", 32'(digits), 32'h0009);
        hitReq[2] = 1'b0;
        tick();

        // Clear mid-ADD aborts; the held request is re-granted from zero.
        hitPoints[7:4] = 4'd4; hitReq[1] = 1'b1;
        tick();
        tick();
        clearScore = 1'b1;
        tick();
        clearScore = 1'b0;
        check("abort_digits", 32'(digits), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_ack", 32'(hitAck), 32'h0);
        wait_ack(a, cy);
        check("regrant_lat", 32'(cy), 32'd5);
        check("regrant_ack", 32'(a), 32'h2);
        check("regrant_digits", 32'(digits), 32'h0004);
        hitReq[1] = 1'b0;
        tick();

        // Saturation at 9999.
        do_clear();
        pump(0, 1110, 4'd8);
        check("pump_9998", 32'(digits), 32'h9998);
        check("pre_ovf", 32'(overflow), 32'h0);
        run_hit(0, 4'd5, a, d, c, cy, s);
        check("sat_digits", 32'(d), 32'h9999);
        check("sat_ovf", 32'(overflow), 32'h1);
        check("sat_chg", 32'(c), 32'h1);
        run_hit(0, 4'd3, a, d, c, cy, s);
        check("post_sat_ack", 32'(a), 32'h1);
        check("post_sat_digits", 32'(d), 32'h9999);
        check("post_sat_chg", 32'(c), 32'h0);
        check("post_sat_ovf", 32'(overflow), 32'h1);
        do_clear();
        check("clr_ovf", 32'({overflow, digits}), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/score_controller.md
# score_controller

Scoring scheduler that sits between the playfield hit sources (bumpers, targets, flippers) and the score digit display blocks. It arbitrates round-robin among point requests and adds each granted value into a multi-digit BCD score, one digit per cycle with ripple carry. It saturates at all-nines and presents stable per-digit BCD nibbles to the digit drawing blocks.

## Interface
Parameters:
- NUM_SOURCES, default 4: number of point requesters.
- NUM_DIGITS, default 4: BCD digits in the score; digit 0 is least significant.

Ports:
- clk  in  1  system clock; one clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high reset.
- clearScore  in  1  new-game clear; highest priority.
- hitReq  in  NUM_SOURCES  level request per source; held until the matching hitAck.
- hitPoints  in  NUM_SOURCES x 4  points per source, 0-9; values above 9 are clamped to 9 when latched.
- hitAck  out  NUM_SOURCES  one-cycle pulse, one-hot; request serviced.
- digits  out  NUM_DIGITS x 4  current score in BCD, registered.
- scoreChanged  out  1  one-cycle pulse when digits take a new value from an addition.
- overflow  out  1  sticky; set when the score saturates.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ADD, DONE.
- IDLE: if any hitReq bit is set, grant the first requesting source after the last granted index, wrapping around.
  - Latch the grant index and the clamped hitPoints.
  - Copy digits into the working register.
  - Clear the carry and digit counter, then go to ADD.
- ADD: one digit per cycle, k = 0..NUM_DIGITS-1.
  - sum = work[k] + (k==0 ? points : 0) + carry.
  - If sum > 9: work[k] = sum-10 and carry = 1. Otherwise work[k] = sum and carry = 0.
  - All NUM_DIGITS cycles always run, so latency is fixed.
- Final ADD cycle (commit edge):
  - If carry out of the MSD is 1: digits become all 9 and overflow is set.
  - Otherwise digits take the working value.
  - hitAck[grant] and scoreChanged are registered high. scoreChanged is suppressed if the points were 0 or the score was already all-nines.
  - Go to DONE.
- DONE: the pulses are visible for this cycle; go to IDLE.
- The round-robin pointer updates at grant. After reset the pointer is NUM_SOURCES-1, so source 0 wins first.
- Request dropped after grant: the addition completes and is acked anyway. Request dropped before grant: ignored.
- hitPoints changing after grant has no effect.
- Once overflow is set, further hits are still acked. digits stay all-nines and scoreChanged stays low.

## Timing
- Reset (and the value on the cycle after clearScore): digits = 0, overflow = 0, hitAck = 0, scoreChanged = 0, busy = 0, state IDLE.
- The RR pointer is reset by reset only. clearScore does not move it.
- clearScore in any state wins over everything:
  - The in-flight addition is aborted with no ack.
  - A still-held request is re-arbitrated from IDLE on the following cycle and added to the cleared score.
- clearScore and reset together: reset behaviour.
- Latency: request sampled in IDLE at cycle t.
  - ADD runs at t+1..t+NUM_DIGITS.
  - DONE at t+NUM_DIGITS+1, where hitAck, scoreChanged and the new digits all appear together.
  - IDLE at t+NUM_DIGITS+2, which can grant again in that same cycle.
  - Throughput: one hit per NUM_DIGITS+2 cycles.
- digits never show a partial sum; they change only at the commit edge or on clear.
- A request arriving while busy waits; no request is ever lost while hitReq is held.

## Structure
- The shared package (defines) holds:
  - the NUM_SOURCES and NUM_DIGITS defaults;
  - typedef bcd_digit_t (logic [3:0]);
  - the FSM state enum score_ctrl_state_t.
- Sub-module rr_arbiter: combinational round-robin grant from hitReq and the pointer, plus a registered pointer update on an accept strobe. It is reusable for other shared display resources.
- The top contains the FSM, the working register, the BCD digit adder and the output registers.
- Each digits[k] drives one digit display instance at its own screen position.

## Test plan
- Reset held 3 cycles, then released -> digits 0000, busy 0, overflow 0, no pulses.
- Source 2 requests with points 7 at cycle 0 -> busy from cycle 1; hitAck = 0100 and scoreChanged at cycle 5; digits 0007 at cycle 5; IDLE at cycle 6.
- Score 0995, source 0 adds 5 -> digits 1000 at commit; the carry ripples through three digits; single scoreChanged.
- Sources 0-3 held simultaneously with points 1, 2, 3, 4 -> acks in order 0, 1, 2, 3, spaced 6 cycles apart; final digits 0010. Then re-raise 1 and 3 -> order 1 then 3, not 3 then 1 (pointer wrap).
- Score 9998, add 5 -> digits 9999 and overflow 1. A further hit of 3 -> acked, digits 9999, scoreChanged 0. Points 12 are latched as 9.
- clearScore asserted during ADD with source 1 holding points 4 -> next cycle digits 0000 and IDLE, no ack. Re-grant follows, and the ack 6 cycles after the clear shows digits 0004.
